result_formatter: RTL and testbench

RESULT_FORMATTER -- requirements
Module: result_formatter

---
 rtl/result_formatter.sv | 105 ++++++++++
 tb/tb_result_formatter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/result_formatter.sv
// result_formatter: streams an ALU result to the UART as uppercase ASCII hex, one byte per transfer.
// Define RESULT_FORMATTER_CRLF_EN to terminate each result with CR LF.
module result_formatter (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [3:0]  dtype,
    input  logic [4:0]  operator,
    input  logic [31:0] calc_res,
    input  logic        alu_done,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        fmt_busy,
    output logic        fmt_done
);
    typedef enum logic [2:0] {
        IDLE, SIGN, DIGIT, SEP
`ifdef RESULT_FORMATTER_CRLF_EN
        , CR, LF
`endif
    } state_t;
    state_t      state;
    logic [31:0] val;
    logic [2:0]  cnt;
    logic        is_div;
    logic        neg;
    logic [31:0] mag;
    function automatic logic [7:0] hex(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : 8'h37 + {4'h0, n};
    endfunction
    always_comb begin
        neg = (operator != 5'h04) && (dtype == 4'h1) && calc_res[31];
        mag = neg ? -calc_res : calc_res;
    end
    // val always holds the digits not yet presented, most significant nibble in [31:28]
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            val      <= '0;
            cnt      <= '0;
            is_div   <= 1'b0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            fmt_busy <= 1'b0;
            fmt_done <= 1'b0;
        end else begin
            fmt_done <= 1'b0;
            if (state == IDLE) begin
                if (alu_done) begin
                    is_div   <= (operator == 5'h04);
                    cnt      <= 3'd0;
                    tx_valid <= 1'b1;
                    fmt_busy <= 1'b1;
                    state    <= neg ? SIGN : DIGIT;
                    tx_data  <= neg ? 8'h2D : hex(mag[31:28]);
                    val      <= neg ? mag : {mag[27:0], 4'h0};
                end
            end else if (tx_valid && tx_ready) begin
                case (state)
                    SIGN, SEP: begin
                        state   <= DIGIT;
                        tx_data <= hex(val[31:28]);
                        val     <= {val[27:0], 4'h0};
                    end
                    DIGIT: begin
                        if (is_div && cnt == 3'd3) begin
                            state   <= SEP;
                            tx_data <= 8'h72;
                            cnt     <= 3'd4;
                        end else if (cnt == 3'd7) begin
`ifdef RESULT_FORMATTER_CRLF_EN
                            state   <= CR;
                            tx_data <= 8'h0D;
`else
                            state    <= IDLE;
                            tx_valid <= 1'b0;
                            tx_data  <= 8'h00;
                            fmt_busy <= 1'b0;
                            fmt_done <= 1'b1;
`endif
                        end else begin
                            tx_data <= hex(val[31:28]);
                            val     <= {val[27:0], 4'h0};
                            cnt     <= cnt + 3'd1;
                        end
                    end
`ifdef RESULT_FORMATTER_CRLF_EN
                    CR: begin
                        state   <= LF;
                        tx_data <= 8'h0A;
                    end
                    LF: begin
                        state    <= IDLE;
                        tx_valid <= 1'b0;
                        tx_data  <= 8'h00;
                        fmt_busy <= 1'b0;
                        fmt_done <= 1'b1;
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_result_formatter.sv
// tb_result_formatter: random and directed result strings checked against a string-building reference model.
module tb_result_formatter;
    logic        clk = 0;
    logic        n_rst = 1;
    logic [3:0]  dtype = 0;
    logic [4:0]  operator = 0;
    logic [31:0] calc_res = 0;
    logic        alu_done = 0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 0;
    logic        fmt_busy;
    logic        fmt_done;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];

    result_formatter dut (
        .clk(clk), .n_rst(n_rst), .dtype(dtype), .operator(operator), .calc_res(calc_res),
        .alu_done(alu_done), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .fmt_busy(fmt_busy), .fmt_done(fmt_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] hexc(input int n);
        return (n < 10) ? 8'(48 + n) : 8'(55 + n);
    endfunction

    // Expected byte string built directly from the textual rules
    task automatic model(input logic [3:0] d, input logic [4:0] o, input logic [31:0] r);
        longint m;
        exp_q.delete();
        if (o == 5'h04) begin
            for (int i = 0; i < 4; i++) exp_q.push_back(hexc(int'((r >> 16) / (32'd1 << (4 * (3 - i)))) % 16));
            exp_q.push_back(8'h72);
            for (int i = 0; i < 4; i++) exp_q.push_back(hexc(int'((r % 65536) / (32'd1 << (4 * (3 - i)))) % 16));
        end else begin
            m = longint'(r);
            if (d == 4'h1 && r[31]) begin
                exp_q.push_back(8'h2D);
                m = 64'h1_0000_0000 - m;
            end
            for (int i = 0; i < 8; i++) exp_q.push_back(hexc(int'((m / (64'd1 << (4 * (7 - i)))) % 16)));
        end
`ifdef RESULT_FORMATTER_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endtask

    // mode: 0 always ready, 1 ready one cycle in three, 2 random ready
    task automatic send(input logic [3:0] d, input logic [4:0] o, input logic [31:0] r,
                        input int mode, input int inject, input int abort);
        int  last = -10;
        bit  pv = 0, px = 0, fin = 0, injected = 0;
        logic [7:0] pd = 0;
        model(d, o, r);
        got_q.delete();
        @(negedge clk);
        dtype = d; operator = o; calc_res = r; alu_done = 1; tx_ready = 0;
        @(negedge clk);
        alu_done = 0;
        check("latency_valid", tx_valid, 1);
        check("latency_busy", fmt_busy, 1);
        for (int c = 0; c < 400 && !fin; c++) begin
            if (c > 0) @(negedge clk);
            alu_done = 0;
            if (pv && !px) begin
                check("hold_valid", tx_valid, 1);
                check("hold_data", tx_data, pd);
            end
            if (!tx_valid) check("idle_data", tx_data, 0);
            if (fmt_done) begin
                check("done_timing", c, last + 1);
                check("done_busy", fmt_busy, 0);
                fin = 1;
            end else begin
                if (abort > 0 && got_q.size() == abort) begin
                    #2 n_rst = 0;
                    #1;
                    check("rst_valid", tx_valid, 0);
                    check("rst_data", tx_data, 0);
                    check("rst_busy", fmt_busy, 0);
                    check("rst_done", fmt_done, 0);
                    @(negedge clk);
                    n_rst = 1; tx_ready = 1;
                    repeat (3) begin
                        @(negedge clk);
                        check("no_resume", tx_valid, 0);
                    end
                    tx_ready = 0;
                    return;
                end
                if (inject >= 0 && got_q.size() == inject && !injected) begin
                    alu_done = 1; calc_res = 32'h0; injected = 1;
                end
                tx_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 3 == 0) : 1'($urandom_range(0, 1));
                px = tx_valid && tx_ready; pv = tx_valid; pd = tx_data;
                if (px) begin
                    got_q.push_back(tx_data);
                    last = c;
                end
            end
        end
        tx_ready = 0;
        if (!fin) check("done_timeout", 0, 1);
        check("length", got_q.size(), exp_q.size());
        foreach (exp_q[i]) check($sformatf("byte%0d", i), (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
        if (mode == 0) check("one_per_cycle", last, exp_q.size() - 1);
        repeat (2) begin
            @(negedge clk);
            check("done_pulse", fmt_done, 0);
            check("stays_idle", tx_valid, 0);
        end
    endtask

    initial begin
        #3 n_rst = 0;
        #1;
        check("reset_valid", tx_valid, 0);
        check("reset_data", tx_data, 0);
        check("reset_busy", fmt_busy, 0);
        check("reset_done", fmt_done, 0);
        repeat (2) @(negedge clk);
        n_rst = 1;
        send(4'h2, 5'h01, 32'h00000008, 0, -1, 0);
        send(4'h1, 5'h02, 32'hFFFFFFFE, 0, -1, 0);
        send(4'h2, 5'h04, 32'h000A0003, 0, -1, 0);
        send(4'h1, 5'h04, 32'hFFFF8001, 0, -1, 0);
        send(4'h1, 5'h03, 32'h80000000, 0, -1, 0);
        send(4'h1, 5'h03, 32'h7FFFFFFF, 0, -1, 0);
        send(4'h2, 5'h01, 32'h1234ABCD, 1, -1, 0);
        send(4'h2, 5'h01, 32'hDEADBEEF, 0, 3, 0);
        send(4'h2, 5'h01, 32'hCAFEF00D, 0, -1, 3);
        send(4'h2, 5'h01, 32'h0F1E2D3C, 0, -1, 0);
        for (int k = 0; k < 25; k++) begin
            logic [3:0]  d;
            logic [4:0]  o;
            logic [31:0] r;
            d = ($urandom_range(0, 3) == 0) ? 4'($urandom) : ($urandom_range(0, 1) ? 4'h1 : 4'h2);
            o = ($urandom_range(0, 2) == 0) ? 5'h04 : 5'($urandom);
            r = $urandom;
            send(d, o, r, 2, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1, 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
